// File: rtl/dac_output_conditioner_if.sv
// Host command bus and sample paths of the DAC output conditioner.
// Host bus: cmd_trig_in is a single-cycle strobe with no back-pressure; every
// strobe is accepted on the edge it is sampled, and a read answers on
// cmd_data_out one cycle later, holding that value until the next read.
interface dac_output_conditioner_if;
  logic        cmd_trig_in;
  logic [15:0] cmd_addr_in;
  logic [15:0] cmd_data_in;
  logic [15:0] cmd_data_out;
  logic [15:0] ch0_in;
  logic [15:0] ch1_in;
  logic [15:0] DAC0_out;
  logic [15:0] DAC1_out;
  logic [5:0]  status_out;

  modport master (
    output cmd_trig_in, cmd_addr_in, cmd_data_in, ch0_in, ch1_in,
    input  cmd_data_out, DAC0_out, DAC1_out, status_out
  );

  modport slave (
    input  cmd_trig_in, cmd_addr_in, cmd_data_in, ch0_in, ch1_in,
    output cmd_data_out, DAC0_out, DAC1_out, status_out
  );
endinterface

// File: rtl/dac_output_conditioner.sv
// Two-channel DAC output conditioner: offset with saturation, window clamp
// and slew-rate limit, configured over the shared host command bus.
module dac_output_conditioner #(
  parameter logic [7:0] GET_CODE = 8'h22,
  parameter logic [7:0] SET_CODE = 8'h23
) (
  input logic                     clk_in,
  input logic                     rst_in,
  dac_output_conditioner_if.slave bus
);
  localparam int NCH = 2;

  // Configuration registers
  logic signed [15:0] ofs_q  [NCH];
  logic signed [15:0] min_q  [NCH];
  logic signed [15:0] max_q  [NCH];
  logic [14:0]        step_q [NCH];
  logic [1:0]         ctrl_q;

  // Status, read data and pipeline-fill tracking
  logic [5:0]  status_q;
  logic [15:0] rd_q;
  logic [2:0]  vld_q;

  // Pipeline registers: S1 offset, S2 clamp, S3 slew (the DAC output)
  logic signed [15:0] s1_q  [NCH];
  logic signed [15:0] s2_q  [NCH];
  logic signed [15:0] out_q [NCH];

  logic [7:0]         idx;
  logic               is_get;
  logic               is_set;
  logic               clr_status;
  logic [15:0]        rd_d;
  logic signed [15:0] in_s   [NCH];
  logic signed [16:0] sum    [NCH];
  logic signed [16:0] diff   [NCH];
  logic signed [16:0] step_s [NCH];
  logic signed [15:0] s1_d   [NCH];
  logic signed [15:0] clip   [NCH];
  logic signed [15:0] s2_d   [NCH];
  logic signed [15:0] out_d  [NCH];
  logic [2:0]         ev     [NCH];
  logic [5:0]         evt;

  assign idx        = bus.cmd_addr_in[7:0];
  assign is_get     = bus.cmd_trig_in && (bus.cmd_addr_in[15:8] == GET_CODE);
  assign is_set     = bus.cmd_trig_in && (bus.cmd_addr_in[15:8] == SET_CODE);
  assign clr_status = is_get && (idx == 8'h09);
  assign in_s[0]    = bus.ch0_in;
  assign in_s[1]    = bus.ch1_in;
  assign evt        = {ev[1], ev[0]};

  // Per-channel datapath: saturating offset, window clamp, slew limit
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      ev[c]  = 3'b000;
      sum[c] = {in_s[c][15], in_s[c]} + {ofs_q[c][15], ofs_q[c]};
      if (!ctrl_q[c]) begin
        s1_d[c] = '0;
      end else if (sum[c] > 17'sh07FFF) begin
        s1_d[c]  = 16'sh7FFF;
        ev[c][0] = 1'b1;
      end else if (sum[c] < 17'sh18000) begin
        s1_d[c]  = 16'sh8000;
        ev[c][0] = 1'b1;
      end else begin
        s1_d[c] = sum[c][15:0];
      end

      // MAX applied first so that MIN wins on an inverted window
      clip[c]  = (s1_q[c] > max_q[c]) ? max_q[c] : s1_q[c];
      s2_d[c]  = (clip[c] < min_q[c]) ? min_q[c] : clip[c];
      ev[c][1] = (s1_q[c] > max_q[c]) || (clip[c] < min_q[c]);

      // Difference kept in 17 bits; a limited step never overshoots the
      // target, so the output stays inside the 16-bit range
      step_s[c] = {2'b00, step_q[c]};
      diff[c]   = {s2_q[c][15], s2_q[c]} - {out_q[c][15], out_q[c]};
      if (diff[c] > step_s[c]) begin
        out_d[c] = out_q[c] + {1'b0, step_q[c]};
        ev[c][2] = 1'b1;
      end else if (diff[c] < -step_s[c]) begin
        out_d[c] = out_q[c] - {1'b0, step_q[c]};
        ev[c][2] = 1'b1;
      end else begin
        out_d[c] = s2_q[c];
      end
    end
  end

  // Register read multiplexer; unknown indices read as zero
  always_comb begin
    rd_d = 16'h0000;
    case (idx)
      8'h00:   rd_d = ofs_q[0];
      8'h01:   rd_d = ofs_q[1];
      8'h02:   rd_d = min_q[0];
      8'h03:   rd_d = max_q[0];
      8'h04:   rd_d = min_q[1];
      8'h05:   rd_d = max_q[1];
      8'h06:   rd_d = {1'b0, step_q[0]};
      8'h07:   rd_d = {1'b0, step_q[1]};
      8'h08:   rd_d = {14'h0000, ctrl_q};
      8'h09:   rd_d = {10'h000, status_q};
      default: rd_d = 16'h0000;
    endcase
  end

  // Configuration register writes; index 0x09 and unknown indices ignored
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ofs_q[0]  <= '0;
      ofs_q[1]  <= '0;
      min_q[0]  <= 16'sh8000;
      min_q[1]  <= 16'sh8000;
      max_q[0]  <= 16'sh7FFF;
      max_q[1]  <= 16'sh7FFF;
      step_q[0] <= 15'h7FFF;
      step_q[1] <= 15'h7FFF;
      ctrl_q    <= 2'b11;
    end else if (is_set) begin
      case (idx)
        8'h00:   ofs_q[0]  <= bus.cmd_data_in;
        8'h01:   ofs_q[1]  <= bus.cmd_data_in;
        8'h02:   min_q[0]  <= bus.cmd_data_in;
        8'h03:   max_q[0]  <= bus.cmd_data_in;
        8'h04:   min_q[1]  <= bus.cmd_data_in;
        8'h05:   max_q[1]  <= bus.cmd_data_in;
        8'h06:   step_q[0] <= bus.cmd_data_in[14:0];
        8'h07:   step_q[1] <= bus.cmd_data_in[14:0];
        8'h08:   ctrl_q    <= bus.cmd_data_in[1:0];
        default: ;
      endcase
    end
  end

  // Read data capture and sticky status; a new event beats the read-clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_q     <= '0;
      status_q <= '0;
      vld_q    <= '0;
    end else begin
      vld_q <= {vld_q[1:0], 1'b1};
      if (is_get) begin
        rd_q <= rd_d;
      end
      status_q <= (clr_status ? 6'h00 : status_q) | (vld_q[2] ? evt : 6'h00);
    end
  end

  // Pipeline advance; reset drops the output to zero with no slew
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int c = 0; c < NCH; c++) begin
        s1_q[c]  <= '0;
        s2_q[c]  <= '0;
        out_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        s1_q[c]  <= s1_d[c];
        s2_q[c]  <= s2_d[c];
        out_q[c] <= out_d[c];
      end
    end
  end

  assign bus.DAC0_out     = out_q[0];
  assign bus.DAC1_out     = out_q[1];
  assign bus.cmd_data_out = rd_q;
  assign bus.status_out   = status_q;
endmodule

// File: tb/tb_dac_output_conditioner.sv
// Bench for dac_output_conditioner: integer reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dac_output_conditioner;
  localparam logic [7:0] GET_CODE = 8'h22;
  localparam logic [7:0] SET_CODE = 8'h23;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_output_conditioner_if bus_if ();

  dac_output_conditioner #(
    .GET_CODE(GET_CODE),
    .SET_CODE(SET_CODE)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_reg [10];
  int m_s1 [2];
  int m_s2 [2];
  int m_out [2];
  int m_status;
  int m_rd;
  int m_edges;

  function automatic int sx(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic int reg_value(input int i);
    if (i <= 8) return m_reg[i];
    if (i == 9) return m_status;
    return 0;
  endfunction

  task automatic model_reset();
    m_reg[0] = 0;      m_reg[1] = 0;
    m_reg[2] = 'h8000; m_reg[3] = 'h7FFF;
    m_reg[4] = 'h8000; m_reg[5] = 'h7FFF;
    m_reg[6] = 'h7FFF; m_reg[7] = 'h7FFF;
    m_reg[8] = 3;      m_reg[9] = 0;
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0;
    end
    m_status = 0;
    m_rd     = 0;
    m_edges  = 0;
  endtask

  task automatic model_step();
    int in_v, x, y, mn, mx, st, d, fl, idx;
    int n_s1 [2];
    int n_s2 [2];
    int n_out [2];
    logic get_c, set_c;
    fl = 0;
    for (int c = 0; c < 2; c++) begin
      in_v = sx(c == 0 ? bus_if.ch0_in : bus_if.ch1_in);
      if (((m_reg[8] >> c) & 1) == 1) begin
        x = in_v + sx(16'(m_reg[c]));
        if (x > 32767) begin x = 32767; fl |= 1 << (3*c); end
        else if (x < -32768) begin x = -32768; fl |= 1 << (3*c); end
      end else begin
        x = 0;
      end
      n_s1[c] = x;
      mn = sx(16'(m_reg[2 + 2*c]));
      mx = sx(16'(m_reg[3 + 2*c]));
      y = m_s1[c];
      if (y > mx) y = mx;
      if (y < mn) y = mn;
      if (m_s1[c] > mx || y < mn) fl |= 1 << (3*c + 1);
      n_s2[c] = y;
      st = m_reg[6 + c];
      d  = m_s2[c] - m_out[c];
      if (d > st) begin n_out[c] = m_out[c] + st; fl |= 1 << (3*c + 2); end
      else if (d < -st) begin n_out[c] = m_out[c] - st; fl |= 1 << (3*c + 2); end
      else n_out[c] = m_s2[c];
    end
    get_c = bus_if.cmd_trig_in && bus_if.cmd_addr_in[15:8] == GET_CODE;
    set_c = bus_if.cmd_trig_in && bus_if.cmd_addr_in[15:8] == SET_CODE;
    idx = int'(bus_if.cmd_addr_in[7:0]);
    if (get_c) m_rd = reg_value(idx);
    if (get_c && idx == 9) m_status = 0;
    if (m_edges >= 3) m_status |= fl;
    if (set_c && idx <= 8) begin
      if (idx == 6 || idx == 7) m_reg[idx] = int'(bus_if.cmd_data_in) & 'h7FFF;
      else if (idx == 8)        m_reg[idx] = int'(bus_if.cmd_data_in) & 3;
      else                      m_reg[idx] = int'(bus_if.cmd_data_in);
    end
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = n_s1[c]; m_s2[c] = n_s2[c]; m_out[c] = n_out[c];
    end
    if (m_edges < 3) m_edges++;
  endtask

  // Model advances with the DUT; reset is asynchronous
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Cycle-by-cycle compare of every output against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("model_dac0",   bus_if.DAC0_out,            16'(m_out[0]));
      check("model_dac1",   bus_if.DAC1_out,            16'(m_out[1]));
      check("model_status", {10'h000, bus_if.status_out}, 16'(m_status));
      check("model_rdata",  bus_if.cmd_data_out,        16'(m_rd));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic raw_cmd(input logic [7:0] code, input logic [7:0] idx, input logic [15:0] data);
    bus_if.cmd_trig_in = 1'b1;
    bus_if.cmd_addr_in = {code, idx};
    bus_if.cmd_data_in = data;
    step();
    bus_if.cmd_trig_in = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] idx, input logic [15:0] data);
    raw_cmd(SET_CODE, idx, data);
  endtask

  task automatic host_read(input string name, input logic [7:0] idx, input logic [15:0] exp);
    exp_q.push_back(exp);
    raw_cmd(GET_CODE, idx, 16'h0000);
    check(name, bus_if.cmd_data_out, exp_q.pop_front());
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    model_reset();
    bus_if.cmd_trig_in = 1'b0;
    bus_if.cmd_addr_in = 16'h0000;
    bus_if.cmd_data_in = 16'h0000;
    bus_if.ch0_in      = 16'h0000;
    bus_if.ch1_in      = 16'h0000;
    rst = 1'b1;
    repeat (3) step();
    check("rst_dac0",   bus_if.DAC0_out, 16'h0000);
    check("rst_dac1",   bus_if.DAC1_out, 16'h0000);
    check("rst_status", {10'h000, bus_if.status_out}, 16'h0000);
    check("rst_rdata",  bus_if.cmd_data_out, 16'h0000);

    // Latency: constant input appears three cycles after reset release
    rst = 1'b0;
    bus_if.ch0_in = 16'h1234;
    step(); step();
    check("lat2_dac0", bus_if.DAC0_out, 16'h0000);
    step();
    check("lat3_dac0", bus_if.DAC0_out, 16'h1234);
    host_read("status_idle", 8'h09, 16'h0000);

    // Offset saturation sets the overflow flag; read clears it
    host_write(8'h00, 16'h7000);
    bus_if.ch0_in = 16'h2000;
    repeat (4) step();
    check("ovf_dac0",   bus_if.DAC0_out, 16'h7FFF);
    check("ovf_status", {10'h000, bus_if.status_out}, 16'h0001);
    bus_if.ch0_in = 16'h0000;
    repeat (4) step();
    check("ofs_dac0", bus_if.DAC0_out, 16'h7000);
    host_read("ovf_read1", 8'h09, 16'h0001);
    host_read("ovf_read2", 8'h09, 16'h0000);
    host_write(8'h00, 16'h0000);

    // Window clamp, then an inverted window where MIN wins
    host_write(8'h04, 16'hFC00);
    host_write(8'h05, 16'h0400);
    bus_if.ch1_in = 16'h1000;
    repeat (4) step();
    check("clamp_dac1",   bus_if.DAC1_out, 16'h0400);
    check("clamp_status", {10'h000, bus_if.status_out}, 16'h0010);
    host_write(8'h04, 16'h0800);
    repeat (4) step();
    check("inv_dac1", bus_if.DAC1_out, 16'h0800);
    bus_if.ch1_in = 16'h0000;
    host_write(8'h04, 16'h8000);
    host_write(8'h05, 16'h7FFF);
    repeat (4) step();
    check("unclamp_dac1", bus_if.DAC1_out, 16'h0000);
    host_read("clamp_read", 8'h09, 16'h0010);

    // Slew ramp up and back down at 0x0100 per cycle
    host_write(8'h06, 16'h0100);
    bus_if.ch0_in = 16'h0A00;
    step(); step();
    for (int k = 1; k <= 10; k++) begin
      step();
      check("ramp_up", bus_if.DAC0_out, 16'(k * 'h100));
    end
    bus_if.ch0_in = 16'h0000;
    step(); step();
    for (int k = 9; k >= 0; k--) begin
      step();
      check("ramp_dn", bus_if.DAC0_out, 16'(k * 'h100));
    end
    host_read("slew_read", 8'h09, 16'h0004);

    // Disabling ch0 decays the output through the slew limiter
    host_write(8'h06, 16'h1000);
    bus_if.ch0_in = 16'h4000;
    repeat (8) step();
    check("pre_decay", bus_if.DAC0_out, 16'h4000);
    host_write(8'h08, 16'h0002);
    step(); step();
    step(); check("decay0", bus_if.DAC0_out, 16'h3000);
    step(); check("decay1", bus_if.DAC0_out, 16'h2000);
    step(); check("decay2", bus_if.DAC0_out, 16'h1000);
    step(); check("decay3", bus_if.DAC0_out, 16'h0000);

    // Reset in the middle of a ramp drops outputs at once
    host_write(8'h08, 16'h0003);
    repeat (4) step();
    check("midramp_dac0", bus_if.DAC0_out, 16'h2000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dac0",   bus_if.DAC0_out, 16'h0000);
    check("async_rst_status", {10'h000, bus_if.status_out}, 16'h0000);
    bus_if.ch0_in = 16'h0000;
    step();
    rst = 1'b0;
    repeat (5) step();
    host_read("rst_step0", 8'h06, 16'h7FFF);
    host_read("rst_ctrl",  8'h08, 16'h0003);

    // New overflow in the same cycle as the STATUS read-clear
    host_write(8'h00, 16'h7000);
    repeat (3) step();
    bus_if.ch0_in = 16'h2000;
    host_read("race_read", 8'h09, 16'h0000);
    check("race_sticky", {10'h000, bus_if.status_out}, 16'h0001);
    bus_if.ch0_in = 16'h0000;
    repeat (4) step();

    // Ignored commands and unknown-index read
    host_write(8'h09, 16'h003F);
    host_write(8'h20, 16'h1234);
    raw_cmd(8'h55, 8'h00, 16'h1234);
    host_read("ofs0_kept", 8'h00, 16'h7000);
    host_read("unk_read",  8'h3F, 16'h0000);
    repeat (2) step();
    check("unk_hold", bus_if.cmd_data_out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
